// File: rtl/i2s_pkg.sv
// Shared I2S receiver definitions: default word width, synchronizer depth and
// the receiver alignment state encoding.
package i2s_pkg;

    localparam int I2S_WIDTH       = 16;
    localparam int I2S_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2si_state_t;

endpackage

// File: rtl/i2si_sync.sv
// N-flop synchronizer for one asynchronous input pin; clears on async reset.
module i2si_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift chain: the pin enters at bit 0 and leaves from the top bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/i2si_rx.sv
// I2S serial receiver: oversamples sck/ws/sd in the clk domain and presents
// left/right pairs on an rts/rtr handshake. Optional I2SI_BITCNT_CHK_EN adds a word-length check.
module i2si_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH       = I2S_WIDTH,
    parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_sck,
    input  logic             inp_ws,
    input  logic             inp_sd,
    input  logic             rf_i2si_en,
    input  logic             trig_i2si_overrun_clr,
    input  logic             i2si_rtr,
    output logic             i2si_rts,
    output logic [WIDTH-1:0] i2si_lft,
    output logic [WIDTH-1:0] i2si_rgt,
    output logic             ro_i2si_overrun
`ifdef I2SI_BITCNT_CHK_EN
    ,
    output logic             ro_i2si_frame_err
`endif
);

    localparam int                CNT_W   = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WIDTH + 1);

    logic             sck_sync_s;
    logic             ws_sync_s;
    logic             sd_sync_s;
    logic             sck_prev_r;
    logic             bit_stb_s;
    logic             boundary_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic             ws_prev_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] lft_hold_r;
    i2si_state_t      state_r;
    i2si_state_t      state_nxt_s;
    logic             load_lft_s;
    logic             frame_done_s;
    logic             frame_ok_s;
    logic             deliver_s;
    logic             accept_s;

    i2si_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst(rst), .d(inp_sck), .q(sck_sync_s));
    i2si_sync #(.STAGES(SYNC_STAGES)) u_sync_ws  (.clk(clk), .rst(rst), .d(inp_ws),  .q(ws_sync_s));
    i2si_sync #(.STAGES(SYNC_STAGES)) u_sync_sd  (.clk(clk), .rst(rst), .d(inp_sd),  .q(sd_sync_s));

    // Bit strobe on synced sck rise; a ws change on that strobe closes a word
    always_comb begin
        bit_stb_s   = sck_sync_s & ~sck_prev_r;
        boundary_s  = bit_stb_s & (ws_sync_s != ws_prev_r);
        shreg_nxt_s = {shreg_r[WIDTH-2:0], sd_sync_s};
        deliver_s   = frame_done_s & frame_ok_s;
        accept_s    = ~i2si_rts | i2si_rtr;
    end

    // Serial shift path, word-select history and saturating bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev_r <= 1'b0;
            shreg_r    <= '0;
            ws_prev_r  <= 1'b0;
            bit_cnt_r  <= '0;
            lft_hold_r <= '0;
        end else begin
            sck_prev_r <= sck_sync_s;
            if (bit_stb_s) begin
                shreg_r   <= shreg_nxt_s;
                ws_prev_r <= ws_sync_s;
                if (boundary_s) begin
                    bit_cnt_r <= '0;
                end else if (bit_cnt_r != CNT_SAT) begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
            end
            if (load_lft_s) begin
                lft_hold_r <= shreg_nxt_s;
            end
        end
    end

    // Alignment state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ALIGN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: ALIGN waits for the end of a right word (ws 1->0)
    always_comb begin
        state_nxt_s  = state_r;
        load_lft_s   = 1'b0;
        frame_done_s = 1'b0;
        if (!rf_i2si_en) begin
            state_nxt_s = ALIGN;
        end else if (boundary_s) begin
            case (state_r)
                ALIGN: begin
                    if (ws_prev_r && !ws_sync_s) begin
                        state_nxt_s = LEFT;
                    end else begin
                        state_nxt_s = ALIGN;
                    end
                end
                LEFT: begin
                    load_lft_s  = 1'b1;
                    state_nxt_s = RIGHT;
                end
                RIGHT: begin
                    frame_done_s = 1'b1;
                    state_nxt_s  = LEFT;
                end
                default: begin
                    state_nxt_s = ALIGN;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output pair and handshake; a frame finishing on a transfer edge reloads at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2si_rts <= 1'b0;
            i2si_lft <= '0;
            i2si_rgt <= '0;
        end else if (!rf_i2si_en) begin
            i2si_rts <= 1'b0;
        end else if (deliver_s && accept_s) begin
            i2si_rts <= 1'b1;
            i2si_lft <= lft_hold_r;
            i2si_rgt <= shreg_nxt_s;
        end else if (i2si_rts && i2si_rtr) begin
            i2si_rts <= 1'b0;
        end
    end

    // Sticky overrun: a set wins over a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_i2si_overrun <= 1'b0;
        end else if (deliver_s && !accept_s) begin
            ro_i2si_overrun <= 1'b1;
        end else if (trig_i2si_overrun_clr) begin
            ro_i2si_overrun <= 1'b0;
        end
    end

`ifdef I2SI_BITCNT_CHK_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic lft_ok_r;
    logic word_ok_s;

    // A full word has WIDTH-1 strobes after the previous boundary plus its LSB strobe
    always_comb begin
        word_ok_s  = (bit_cnt_r == CNT_LAST);
        frame_ok_s = word_ok_s & lft_ok_r;
    end

    // Left-word verdict and sticky frame-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_ok_r          <= 1'b0;
            ro_i2si_frame_err <= 1'b0;
        end else begin
            if (load_lft_s) begin
                lft_ok_r <= word_ok_s;
            end
            if ((load_lft_s || frame_done_s) && !word_ok_s) begin
                ro_i2si_frame_err <= 1'b1;
            end else if (trig_i2si_overrun_clr) begin
                ro_i2si_frame_err <= 1'b0;
            end
        end
    end
`else
    assign frame_ok_s = 1'b1;
`endif

endmodule

// File: tb/tb_i2si_rx.sv
// Directed self-checking bench for i2si_rx: drives I2S frames bit by bit and
// compares outputs against hand-computed values.
module tb_i2si_rx;
    import i2s_pkg::*;

    localparam int W = I2S_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inp_sck = 1'b0;
    logic         inp_ws = 1'b0;
    logic         inp_sd = 1'b0;
    logic         rf_i2si_en = 1'b0;
    logic         trig_i2si_overrun_clr = 1'b0;
    logic         i2si_rtr = 1'b0;
    logic         i2si_rts;
    logic [W-1:0] i2si_lft;
    logic [W-1:0] i2si_rgt;
    logic         ro_i2si_overrun;
`ifdef I2SI_BITCNT_CHK_EN
    logic         ro_i2si_frame_err;
`endif

    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           half = 40;
    int           xfer_cnt = 0;
    logic [W-1:0] xfer_lft = '0;
    logic [W-1:0] xfer_rgt = '0;

    i2si_rx dut (
        .clk                   (clk),
        .rst                   (rst),
        .inp_sck               (inp_sck),
        .inp_ws                (inp_ws),
        .inp_sd                (inp_sd),
        .rf_i2si_en            (rf_i2si_en),
        .trig_i2si_overrun_clr (trig_i2si_overrun_clr),
        .i2si_rtr              (i2si_rtr),
        .i2si_rts              (i2si_rts),
        .i2si_lft              (i2si_lft),
        .i2si_rgt              (i2si_rgt),
        .ro_i2si_overrun       (ro_i2si_overrun)
`ifdef I2SI_BITCNT_CHK_EN
        ,
        .ro_i2si_frame_err     (ro_i2si_frame_err)
`endif
    );

    always #5 clk = ~clk;

    // Record every handshake transfer seen at a clock edge
    always @(posedge clk) begin
        if (i2si_rts === 1'b1 && i2si_rtr === 1'b1) begin
            xfer_cnt <= xfer_cnt + 1;
            xfer_lft <= i2si_lft;
            xfer_rgt <= i2si_rgt;
        end
    end

    task automatic drive_bit(input logic ws, input logic sd);
        @(negedge clk);
        inp_sck = 1'b0;
        inp_ws  = ws;
        inp_sd  = sd;
        repeat (half) @(negedge clk);
        inp_sck = 1'b1;
        repeat (half - 1) @(negedge clk);
    endtask

    // ws flips on the LSB slot, one bit before the next word's MSB
    task automatic send_word(input logic ch, input logic [W-1:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            drive_bit((i == 0) ? ~ch : ch, data[i]);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_word(1'b0, l, W);
        send_word(1'b1, r, W);
    endtask

    // Everything except the right LSB, then raise sck for that LSB and return
    task automatic send_open(input logic [W-1:0] l, input logic [W-1:0] r);
        send_word(1'b0, l, W);
        for (int i = W - 1; i >= 1; i--) begin
            drive_bit(1'b1, r[i]);
        end
        @(negedge clk);
        inp_sck = 1'b0;
        inp_ws  = 1'b0;
        inp_sd  = r[0];
        repeat (half) @(negedge clk);
        inp_sck = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++; if (i2si_rts !== 1'b0) begin err_cnt++; $display("FAIL reset_rts: got %b want 0", i2si_rts); end
        vec_cnt++; if (i2si_lft !== 16'h0000) begin err_cnt++; $display("FAIL reset_lft: got %h want 0000", i2si_lft); end
        vec_cnt++; if (i2si_rgt !== 16'h0000) begin err_cnt++; $display("FAIL reset_rgt: got %h want 0000", i2si_rgt); end
        vec_cnt++; if (ro_i2si_overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_ovr: got %b want 0", ro_i2si_overrun); end
`ifdef I2SI_BITCNT_CHK_EN
        vec_cnt++; if (ro_i2si_frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_ferr: got %b want 0", ro_i2si_frame_err); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        half       = 40;
        rf_i2si_en = 1'b1;
        i2si_rtr   = 1'b1;
        send_word(1'b1, 16'h0000, W);
        send_open(16'hA5F0, 16'h0F3C);
        @(negedge clk);
        vec_cnt++; if (i2si_rts !== 1'b0) begin err_cnt++; $display("FAIL basic_rts_c1: got %b want 0", i2si_rts); end
        @(negedge clk);
        vec_cnt++; if (i2si_rts !== 1'b0) begin err_cnt++; $display("FAIL basic_rts_c2: got %b want 0", i2si_rts); end
        @(negedge clk);
        vec_cnt++; if (i2si_rts !== 1'b1) begin err_cnt++; $display("FAIL basic_rts_c3: got %b want 1", i2si_rts); end
        vec_cnt++; if (i2si_lft !== 16'hA5F0) begin err_cnt++; $display("FAIL basic_lft: got %h want a5f0", i2si_lft); end
        vec_cnt++; if (i2si_rgt !== 16'h0F3C) begin err_cnt++; $display("FAIL basic_rgt: got %h want 0f3c", i2si_rgt); end
        @(negedge clk);
        vec_cnt++; if (i2si_rts !== 1'b0) begin err_cnt++; $display("FAIL basic_rts_c4: got %b want 0", i2si_rts); end
        vec_cnt++; if (xfer_cnt !== 1) begin err_cnt++; $display("FAIL basic_xfer: got %0d want 1", xfer_cnt); end
        repeat (half - 5) @(negedge clk);
    endtask

    task automatic test_alignment;
        half = 10;
        @(negedge clk);
        rf_i2si_en = 1'b0;
        send_word(1'b0, 16'h1111, W);
        for (int i = W - 1; i >= 10; i--) drive_bit(1'b1, 1'b1);
        rf_i2si_en = 1'b1;
        for (int i = 9; i >= 1; i--) drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b1);
        send_word(1'b0, 16'hBEEF, W);
        vec_cnt++; if (xfer_cnt !== 1) begin err_cnt++; $display("FAIL align_early: got %0d transfers want 1", xfer_cnt); end
        send_word(1'b1, 16'hCAFE, W);
        vec_cnt++; if (xfer_cnt !== 2) begin err_cnt++; $display("FAIL align_xfer: got %0d want 2", xfer_cnt); end
        vec_cnt++; if (xfer_lft !== 16'hBEEF) begin err_cnt++; $display("FAIL align_lft: got %h want beef", xfer_lft); end
        vec_cnt++; if (xfer_rgt !== 16'hCAFE) begin err_cnt++; $display("FAIL align_rgt: got %h want cafe", xfer_rgt); end
    endtask

    task automatic test_backpressure;
        i2si_rtr = 1'b0;
        send_frame(16'h1111, 16'h2222);
        vec_cnt++; if (i2si_rts !== 1'b1) begin err_cnt++; $display("FAIL bp_rts1: got %b want 1", i2si_rts); end
        vec_cnt++; if (ro_i2si_overrun !== 1'b0) begin err_cnt++; $display("FAIL bp_ovr0: got %b want 0", ro_i2si_overrun); end
        send_frame(16'h3333, 16'h4444);
        vec_cnt++; if (i2si_lft !== 16'h1111) begin err_cnt++; $display("FAIL bp_lft: got %h want 1111", i2si_lft); end
        vec_cnt++; if (i2si_rgt !== 16'h2222) begin err_cnt++; $display("FAIL bp_rgt: got %h want 2222", i2si_rgt); end
        vec_cnt++; if (ro_i2si_overrun !== 1'b1) begin err_cnt++; $display("FAIL bp_ovr1: got %b want 1", ro_i2si_overrun); end
        @(negedge clk);
        trig_i2si_overrun_clr = 1'b1;
        @(negedge clk);
        trig_i2si_overrun_clr = 1'b0;
        vec_cnt++; if (ro_i2si_overrun !== 1'b0) begin err_cnt++; $display("FAIL bp_clr: got %b want 0", ro_i2si_overrun); end
        vec_cnt++; if (xfer_cnt !== 2) begin err_cnt++; $display("FAIL bp_xfer: got %0d want 2", xfer_cnt); end
    endtask

    task automatic test_simultaneous;
        send_open(16'h5555, 16'h6666);
        repeat (2) @(negedge clk);
        i2si_rtr = 1'b1;
        @(negedge clk);
        i2si_rtr = 1'b0;
        vec_cnt++; if (i2si_rts !== 1'b1) begin err_cnt++; $display("FAIL sim_rts: got %b want 1", i2si_rts); end
        vec_cnt++; if (i2si_lft !== 16'h5555) begin err_cnt++; $display("FAIL sim_lft: got %h want 5555", i2si_lft); end
        vec_cnt++; if (i2si_rgt !== 16'h6666) begin err_cnt++; $display("FAIL sim_rgt: got %h want 6666", i2si_rgt); end
        vec_cnt++; if (ro_i2si_overrun !== 1'b0) begin err_cnt++; $display("FAIL sim_ovr: got %b want 0", ro_i2si_overrun); end
        vec_cnt++; if (xfer_lft !== 16'h1111) begin err_cnt++; $display("FAIL sim_old_lft: got %h want 1111", xfer_lft); end
        repeat (half - 4) @(negedge clk);
        i2si_rtr = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++; if (xfer_cnt !== 4) begin err_cnt++; $display("FAIL sim_xfer: got %0d want 4", xfer_cnt); end
        vec_cnt++; if (xfer_rgt !== 16'h6666) begin err_cnt++; $display("FAIL sim_new_rgt: got %h want 6666", xfer_rgt); end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] d;
        d = 16'h1357;
        for (int i = W - 1; i >= 8; i--) drive_bit(1'b0, d[i]);
        @(negedge clk);
        inp_sck = 1'b0;
        inp_ws  = 1'b0;
        inp_sd  = d[7];
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++; if (i2si_lft !== 16'h0000) begin err_cnt++; $display("FAIL rmid_lft: got %h want 0000", i2si_lft); end
        vec_cnt++; if (i2si_rgt !== 16'h0000) begin err_cnt++; $display("FAIL rmid_rgt: got %h want 0000", i2si_rgt); end
        vec_cnt++; if (i2si_rts !== 1'b0) begin err_cnt++; $display("FAIL rmid_rts: got %b want 0", i2si_rts); end
        rst = 1'b0;
        repeat (half - 3) @(negedge clk);
        inp_sck = 1'b1;
        repeat (half - 1) @(negedge clk);
        for (int i = 6; i >= 1; i--) drive_bit(1'b0, d[i]);
        drive_bit(1'b1, d[0]);
        send_word(1'b1, 16'h2468, W);
        vec_cnt++; if (xfer_cnt !== 4) begin err_cnt++; $display("FAIL rmid_spurious: got %0d transfers want 4", xfer_cnt); end
        send_frame(16'h9ABC, 16'hDEF0);
        vec_cnt++; if (xfer_cnt !== 5) begin err_cnt++; $display("FAIL rmid_xfer: got %0d want 5", xfer_cnt); end
        vec_cnt++; if (xfer_lft !== 16'h9ABC) begin err_cnt++; $display("FAIL rmid_lft2: got %h want 9abc", xfer_lft); end
        vec_cnt++; if (xfer_rgt !== 16'hDEF0) begin err_cnt++; $display("FAIL rmid_rgt2: got %h want def0", xfer_rgt); end
    endtask

`ifdef I2SI_BITCNT_CHK_EN
    task automatic test_bitcnt;
        send_word(1'b0, 16'h7FFF, W - 1);
        send_word(1'b1, 16'h1234, W);
        vec_cnt++; if (ro_i2si_frame_err !== 1'b1) begin err_cnt++; $display("FAIL bc_ferr: got %b want 1", ro_i2si_frame_err); end
        vec_cnt++; if (xfer_cnt !== 5) begin err_cnt++; $display("FAIL bc_drop: got %0d transfers want 5", xfer_cnt); end
        vec_cnt++; if (ro_i2si_overrun !== 1'b0) begin err_cnt++; $display("FAIL bc_ovr: got %b want 0", ro_i2si_overrun); end
        send_frame(16'h0F0F, 16'hF0F0);
        vec_cnt++; if (xfer_cnt !== 6) begin err_cnt++; $display("FAIL bc_next: got %0d want 6", xfer_cnt); end
        vec_cnt++; if (xfer_lft !== 16'h0F0F) begin err_cnt++; $display("FAIL bc_lft: got %h want 0f0f", xfer_lft); end
        @(negedge clk);
        trig_i2si_overrun_clr = 1'b1;
        @(negedge clk);
        trig_i2si_overrun_clr = 1'b0;
        vec_cnt++; if (ro_i2si_frame_err !== 1'b0) begin err_cnt++; $display("FAIL bc_clr: got %b want 0", ro_i2si_frame_err); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_alignment;
        test_backpressure;
        test_simultaneous;
        test_reset_mid;
`ifdef I2SI_BITCNT_CHK_EN
        test_bitcnt;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
